// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its feeder: default geometry,
// feeder FSM states and the lane-packing helper used on every lane bus.
package systolic_pkg;

  localparam int DATA_SIZE = 16;
  localparam int SIZE      = 3;

  typedef enum logic [2:0] {
    IDLE,
    W_COLLECT,
    W_PUSH,
    W_GAP,
    STREAM,
    DRAIN
  } feeder_state_t;

  // LSB position of lane r on an n-lane bus of w-bit elements; lane 0 sits in the MSBs.
  function automatic int lane_lo(input int r, input int n, input int w);
    return (n - 1 - r) * w;
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO with fall-through read port: rd_data shows the head entry
// whenever empty is low. Pushes while full and pops while empty are ignored.
module feeder_fifo #(
  parameter int width = 49,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             wr_data,
  input  logic                         pop,
  output logic [width-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(depth - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(depth - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Front end of the weight-stationary array: loads one weight matrix, replays it
// on set_w/w_stream, then streams buffered vectors with per-lane diagonal skew.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int size      = SIZE,
  parameter int depth     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [data_size*size-1:0] w_in,
  input  logic                      w_in_valid,
  output logic                      w_in_ready,
  input  logic [data_size*size-1:0] x_in,
  input  logic                      x_in_valid,
  input  logic                      x_in_last,
  output logic                      x_in_ready,
  output logic                      set_w,
  output logic [data_size*size-1:0] w_stream,
  output logic [data_size*size-1:0] data_stream,
  output logic [size-1:0]           lane_valid,
  output logic                      batch_done
);

  localparam int BW   = data_size * size;
  localparam int CW   = (size > 1) ? $clog2(size) : 1;
  localparam int DW   = $clog2(2 * size);
  localparam int CNTW = $clog2(depth + 1);

  feeder_state_t   state;
  feeder_state_t   state_n;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   pcnt;
  logic [CW-1:0]   pcnt_n;
  logic [DW-1:0]   dcnt;
  logic [BW-1:0]   row_buf [size];

  logic            pop;
  logic            fifo_empty;
  logic            unused_fifo_full;
  logic [CNTW-1:0] fifo_count;
  logic [BW:0]     fifo_rd;
  logic [BW-1:0]   fifo_x;
  logic            fifo_last;

  feeder_fifo #(
    .width (BW + 1),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (x_in_valid && !reset),
    .wr_data ({x_in, x_in_last}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (unused_fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign x_in_ready = (fifo_count < CNTW'(depth));
  assign fifo_x     = fifo_rd[BW:1];
  assign fifo_last  = fifo_rd[0];

  always_comb begin
    state_n    = state;
    pcnt_n     = '0;
    w_in_ready = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE, W_COLLECT: begin
        w_in_ready = 1'b1;
        if (w_in_valid) state_n = (wcnt == CW'(size - 1)) ? W_PUSH : W_COLLECT;
      end
      W_PUSH: begin
        if (pcnt == CW'(size - 1)) state_n = W_GAP;
        else                       pcnt_n  = pcnt + 1'b1;
      end
      W_GAP:  state_n = STREAM;
      STREAM: begin
        pop = !fifo_empty;
        if (pop && fifo_last) state_n = DRAIN;
      end
      DRAIN:   if (dcnt == DW'(2 * size - 2)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // set_w/w_stream are registered from the next state so they line up with W_PUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      pcnt       <= '0;
      dcnt       <= '0;
      set_w      <= 1'b0;
      w_stream   <= '0;
      batch_done <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= pcnt_n;
      if (w_in_valid && w_in_ready)
        wcnt <= (wcnt == CW'(size - 1)) ? '0 : wcnt + 1'b1;
      dcnt       <= (state == DRAIN && state_n == DRAIN) ? dcnt + 1'b1 : '0;
      set_w      <= (state_n == W_PUSH);
      w_stream   <= (state_n == W_PUSH) ? row_buf[pcnt_n] : '0;
      batch_done <= (state == DRAIN) && (state_n == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_valid && w_in_ready) row_buf[wcnt] <= w_in;
  end

  for (genvar r = 0; r < size; r++) begin : g_lane
    localparam int LO = lane_lo(r, size, data_size);

    logic [data_size-1:0] x_pn [r+1];
    logic [r:0]           vld_pn;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) x_pn[i] <= '0;
        vld_pn <= '0;
      end else begin
        // stage 0: popped lane element, or zero on a bubble
        x_pn[0]   <= pop ? fifo_x[LO +: data_size] : '0;
        vld_pn[0] <= pop;
        // stages 1..r: diagonal skew delay
        for (int i = 1; i <= r; i++) begin
          x_pn[i]   <= x_pn[i-1];
          vld_pn[i] <= vld_pn[i-1];
        end
      end
    end

    assign data_stream[LO +: data_size] = x_pn[r];
    assign lane_valid[r]                = vld_pn[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a timeline model schedules expected outputs per cycle
// from accepted rows, FIFO pops and resets; directed sequences pin literal values.
module tb_systolic_feeder;

  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int DP = 4;
  localparam int BW = DS * SZ;
  localparam int H  = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] w_in, x_in;
  logic          w_in_valid, x_in_valid, x_in_last;
  logic          w_in_ready, x_in_ready, set_w, batch_done;
  logic [BW-1:0] w_stream, data_stream;
  logic [SZ-1:0] lane_valid;

  always #5 clk = ~clk;

  systolic_feeder #(.data_size(DS), .size(SZ), .depth(DP)) dut (
    .clk         (clk),
    .reset       (reset),
    .w_in        (w_in),
    .w_in_valid  (w_in_valid),
    .w_in_ready  (w_in_ready),
    .x_in        (x_in),
    .x_in_valid  (x_in_valid),
    .x_in_last   (x_in_last),
    .x_in_ready  (x_in_ready),
    .set_w       (set_w),
    .w_stream    (w_stream),
    .data_stream (data_stream),
    .lane_valid  (lane_valid),
    .batch_done  (batch_done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle, scheduled ahead of time by the model.
  bit [BW-1:0] e_data [H];
  bit [SZ-1:0] e_lv   [H];
  bit          e_setw [H];
  bit [BW-1:0] e_w    [H];
  bit          e_done [H];

  typedef struct packed {
    logic [BW-1:0] v;
    logic          last;
  } ent_t;

  ent_t          mq [$];
  logic [BW-1:0] mrows [SZ];
  int            mwcnt       = 0;
  int            stream_from = -1;
  int            reopen_at   = -1;
  bit            m_wopen     = 1'b1;
  bit            streaming   = 1'b0;
  bit            chk_en      = 1'b0;

  always @(posedge clk) begin : model
    int   p;
    bit   xr;
    ent_t e;
    p = cyc;
    if (reset) begin
      mq.delete();
      mwcnt = 0; m_wopen = 1'b1; streaming = 1'b0; stream_from = -1; reopen_at = -1;
      for (int c = p + 1; c < p + 16 && c < H; c++) begin
        e_data[c] = '0; e_lv[c] = '0; e_setw[c] = 1'b0; e_w[c] = '0; e_done[c] = 1'b0;
      end
    end else begin
      xr = (mq.size() < DP);
      if (m_wopen && w_in_valid) begin
        mrows[mwcnt] = w_in;
        mwcnt++;
        if (mwcnt == SZ) begin
          mwcnt = 0;
          m_wopen = 1'b0;
          for (int i = 0; i < SZ; i++) begin
            e_setw[p + 1 + i] = 1'b1;
            e_w[p + 1 + i]    = mrows[i];
          end
          stream_from = p + SZ + 2;
        end
      end
      if (streaming && mq.size() > 0) begin
        e = mq.pop_front();
        for (int r = 0; r < SZ; r++) begin
          e_data[p + 1 + r][(SZ - r) * DS - 1 -: DS] = e.v[(SZ - r) * DS - 1 -: DS];
          e_lv[p + 1 + r][r] = 1'b1;
        end
        if (e.last) begin
          streaming = 1'b0;
          e_done[p + 2 * SZ] = 1'b1;
          reopen_at = p + 2 * SZ;
        end
      end
      if (x_in_valid && xr) begin
        e.v = x_in;
        e.last = x_in_last;
        mq.push_back(e);
      end
      if (stream_from == p + 1) streaming = 1'b1;
      if (reopen_at == p + 1)   m_wopen = 1'b1;
    end
    cyc = p + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("set_w",       set_w,       e_setw[cyc]);
      chk("w_stream",    w_stream,    e_w[cyc]);
      chk("data_stream", data_stream, e_data[cyc]);
      chk("lane_valid",  lane_valid,  e_lv[cyc]);
      chk("batch_done",  batch_done,  e_done[cyc]);
      chk("w_in_ready",  w_in_ready,  m_wopen);
      chk("x_in_ready",  x_in_ready,  mq.size() < DP);
    end
  end

  task automatic load_w(input logic [BW-1:0] r0, input logic [BW-1:0] r1, input logic [BW-1:0] r2);
    logic [BW-1:0] rr [3];
    rr = '{r0, r1, r2};
    for (int i = 0; i < 3; i++) begin
      w_in = rr[i];
      w_in_valid = 1'b1;
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    w_in = '0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (batch_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("batch_done_seen", batch_done, 1);
    @(negedge clk);
  endtask

  initial begin : stim
    logic [BW-1:0] wexp  [3];
    logic [BW-1:0] dsexp [3];
    logic [SZ-1:0] lvexp [3];
    reset = 1'b1;
    w_in = '0; w_in_valid = 1'b0;
    x_in = '0; x_in_valid = 1'b0; x_in_last = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_set_w", set_w, 0);
    chk("rst_data", data_stream, 0);
    chk("rst_lv", lane_valid, 0);
    chk("rst_done", batch_done, 0);
    chk("rst_x_rdy", x_in_ready, 1);
    chk("rst_w_rdy", w_in_ready, 1);

    // weight load, then a single skewed vector
    wexp = '{48'h0001_0002_0003, 48'h0004_0005_0006, 48'h0007_0008_0009};
    load_w(wexp[0], wexp[1], wexp[2]);
    for (int i = 0; i < 3; i++) begin
      chk("t2_set_w", set_w, 1);
      chk("t2_w_row", w_stream, wexp[i]);
      @(negedge clk);
    end
    chk("t2_gap", set_w, 0);
    x_in = {16'd1, 16'd2, 16'd3}; x_in_last = 1'b1; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0; x_in_last = 1'b0;
    @(negedge clk);
    lvexp = '{3'b001, 3'b010, 3'b100};
    dsexp = '{48'h0001_0000_0000, 48'h0000_0002_0000, 48'h0000_0000_0003};
    for (int i = 0; i < 3; i++) begin
      chk("t3_lv", lane_valid, lvexp[i]);
      chk("t3_data", data_stream, dsexp[i]);
      @(negedge clk);
    end
    chk("t3_done_early", batch_done, 0);
    @(negedge clk);
    chk("t3_done_early", batch_done, 0);
    @(negedge clk);
    chk("t3_done", batch_done, 1);
    @(negedge clk);

    // FIFO fills while weights are being collected
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        w_in = wexp[i] ^ 48'h0100_0100_0100;
        w_in_valid = 1'b1;
      end else begin
        w_in_valid = 1'b0;
      end
      x_in = {16'(10 * i + 1), 16'(10 * i + 2), 16'(10 * i + 3)};
      x_in_last = (i == 4);
      x_in_valid = 1'b1;
      if (i == 4) chk("t4_full_rdy", x_in_ready, 0);
      else        chk("t4_rdy", x_in_ready, 1);
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("t4_hold", x_in_ready, 0);
      @(negedge clk);
    end
    chk("t4_reopen", x_in_ready, 1);
    @(negedge clk);
    x_in_valid = 1'b0; x_in_last = 1'b0;
    wait_done(40);

    // bubble: A, two empty cycles, B(last)
    load_w(48'h0002_0003_0004, 48'h0005_0006_0007, 48'h0008_0009_000a);
    repeat (4) @(negedge clk);
    x_in = 48'h00a1_00a2_00a3; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_l0_a", data_stream[47:32], 16'h00a1);
    chk("t5_v0_a", lane_valid[0], 1);
    @(negedge clk);
    x_in = 48'h00b1_00b2_00b3; x_in_last = 1'b1; x_in_valid = 1'b1;
    chk("t5_l0_gap", data_stream[47:32], 16'h0000);
    chk("t5_v0_gap", lane_valid[0], 0);
    chk("t5_l1_a", data_stream[31:16], 16'h00a2);
    @(negedge clk);
    x_in_valid = 1'b0; x_in_last = 1'b0;
    chk("t5_l0_gap2", data_stream[47:32], 16'h0000);
    chk("t5_v0_gap2", lane_valid[0], 0);
    chk("t5_l2_a", data_stream[15:0], 16'h00a3);
    @(negedge clk);
    chk("t5_l0_b", data_stream[47:32], 16'h00b1);
    chk("t5_v0_b", lane_valid[0], 1);
    wait_done(20);

    // reset in the second push cycle, then a fresh load starts at row 0
    load_w(48'h0011_0012_0013, 48'h0021_0022_0023, 48'h0031_0032_0033);
    chk("t6_push0", w_stream, 48'h0011_0012_0013);
    @(negedge clk);
    chk("t6_push1", w_stream, 48'h0021_0022_0023);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_set_w_off", set_w, 0);
    chk("t6_w_rdy", w_in_ready, 1);
    load_w(48'h0101_0102_0103, 48'h0201_0202_0203, 48'h0301_0302_0303);
    chk("t6_set_w_on", set_w, 1);
    chk("t6_row0_first", w_stream, 48'h0101_0102_0103);

    // reset for two cycles in the middle of a stream
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      x_in = {16'(i + 5), 16'(i + 6), 16'(i + 7)};
      x_in_valid = 1'b1;
      @(negedge clk);
    end
    x_in_valid = 1'b0;
    chk("t1_active", lane_valid != '0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_set_w", set_w, 0);
    chk("t1_data", data_stream, 0);
    chk("t1_lv", lane_valid, 0);
    chk("t1_done", batch_done, 0);
    chk("t1_x_rdy", x_in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    chk("t1_data_hold", data_stream, 0);

    // recovery batch after the abandoned one
    load_w(48'h0003_0002_0001, 48'h0006_0005_0004, 48'h0009_0008_0007);
    x_in = 48'h0c01_0c02_0c03; x_in_last = 1'b1; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0; x_in_last = 1'b0;
    wait_done(30);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Upstream stage of the weight-stationary systolic array. It collects one weight matrix row by row and replays it on set_w/w_stream for exactly size consecutive cycles. It then buffers input vectors in a small FIFO and drives them onto data_stream with per-lane diagonal skew (lane r delayed r cycles), inserting zeros on bubbles and flushing the array after the last vector of a batch.

Parameters:
data_size, 16, width of one lane element (gdo number format)
size, 3, array dimension: lanes per vector and rows per weight matrix
depth, 4, input FIFO depth in vectors (>= 2)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
w_in  in  data_size*size  one weight row; lane 0 in MSBs
w_in_valid  in  1  w_in holds a valid row
w_in_ready  out  1  feeder accepts a weight row this cycle
x_in  in  data_size*size  one input vector; lane 0 in MSBs
x_in_valid  in  1  x_in holds a valid vector
x_in_last  in  1  marks the last vector of a batch; sampled with x_in_valid
x_in_ready  out  1  FIFO not full
set_w  out  1  weight write strobe to array
w_stream  out  data_size*size  weight row to array
data_stream  out  data_size*size  skewed activations to array
lane_valid  out  size  bit r set when lane r of data_stream carries real data
batch_done  out  1  one-cycle pulse when batch fully flushed

Behaviour:
- Reset (sync, active-high): state IDLE; FIFO empty; weight buffer counter 0. Outputs set_w, w_stream, data_stream, lane_valid and batch_done all 0. Reset mid-operation abandons the batch, and set_w is 0 the cycle after the reset edge.
- Lane packing: lane r occupies bits [(size-r)*data_size-1 -: data_size] on every bus.
- FSM states: IDLE, W_COLLECT, W_PUSH, W_GAP, STREAM, DRAIN.
- IDLE and W_COLLECT: w_in_ready=1. Each w_in_valid&&w_in_ready stores the row at index wcnt and increments wcnt. When row size-1 is stored, go to W_PUSH with pcnt=0.
- W_PUSH: set_w=1 and w_stream=row[pcnt] (registered outputs) for exactly size consecutive cycles, rows 0..size-1 in order. Then go to W_GAP. w_in_ready=0.
- W_GAP: set_w=0 for exactly one cycle so the array's row counter clears. Then go to STREAM.
- STREAM: each cycle, if FIFO non-empty, pop one vector. If it was tagged last, go to DRAIN.
- DRAIN: runs for 2*size-1 cycles, then IDLE with batch_done=1 for one cycle. w_in_ready stays 0 in every state except IDLE and W_COLLECT.
- FIFO:
  - Stores {x_in, x_in_last}. x_in_ready = (count < depth), computed from count only.
  - Push is allowed in every state except during reset, so the next batch may prefetch.
  - A push while full is not accepted, even when a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count unchanged.
- Skew pipeline:
  - Stage 0 register takes the popped vector and valid=1. If there is no pop (bubble, DRAIN, or any non-STREAM state), it takes zero data and valid=0.
  - Lane r output = stage-0 lane r delayed r further cycles through a shift chain.
  - A vector popped at cycle k appears on lane r at cycle k+1+r; lane_valid[r] follows the same timing.
  - Zero fill keeps array sums clean, since the gdo product with 0 is 0.
- No arithmetic in this block; all widths pass through unchanged.

Decomposition:
- Shared package systolic_pkg holds:
  - data_size/size defaults;
  - an enum feeder_state_t {IDLE, W_COLLECT, W_PUSH, W_GAP, STREAM, DRAIN};
  - a lane-slice helper function used by both this block and the array.
- Sub-module: feeder_fifo, a parameterised synchronous FIFO (width data_size*size+1, depth) exposing full, empty and count.
- The skew chain and FSM stay in systolic_feeder.

Test Plan:
1. Reset: assert reset 2 cycles mid-stream -> set_w=0, data_stream=0, lane_valid=0, batch_done=0, x_in_ready=1 the cycle after the reset edge.
2. Weight load, size=3: rows 0x0001_0002_0003, 0x0004_0005_0006, 0x0007_0008_0009 offered on consecutive cycles -> set_w=1 for exactly 3 consecutive cycles with w_stream equal to those rows in order, then set_w=0 for at least 1 cycle.
3. Skew: single vector (1,2,3) with last, popped at cycle k:
   - lane0=1 at k+1, lane1=2 at k+2, lane2=3 at k+3, each with its lane_valid bit;
   - all lanes 0 otherwise;
   - batch_done=1 at cycle k+6.
4. FIFO full: depth=4, 5 vectors pushed during W_COLLECT -> first 4 accepted; x_in_ready=0 on the 5th until the first STREAM pop.
5. Bubble: vectors A, gap of 2 cycles, B(last) -> lane 0 shows A, 0, 0, B with lane_valid[0]=1,0,0,1; lanes 1/2 show the same pattern shifted by 1/2 cycles.
6. Reset during W_PUSH (second push cycle) -> set_w=0 next cycle; the next weight load sends row 0 first.
